// File: rtl/kernel_ram.sv
// kernel_ram: one neighbourhood cell of the skeletonization array.
// Snoops the raster-ordered N x N image write stream, latches the 3x3
// neighbourhood around centre pixel `identifier`, and registers the centre
// pixel that survives one Zhang-Suen thinning sub-iteration.
//
// Configuration macro: KERNEL_RAM_SUBITER2_EN
//   undefined -> first sub-iteration  (b2*b4*b6 == 0, b4*b6*b8 == 0)
//   defined   -> second sub-iteration (b2*b4*b8 == 0, b2*b6*b8 == 0)
//
// Interface semantics: there is no valid/ready handshake. Every edge with
// we=1 is a write of data_in to address; the cell never stalls the stream
// and accepts back-to-back or repeated writes to the same address.
module kernel_ram #(
    parameter int N          = 8,
    parameter int bitSize    = 6,
    parameter int pixelWidth = 8,
    parameter int identifier = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [bitSize:0]      address,
    input  logic [pixelWidth-1:0] data_in,
    output logic [pixelWidth-1:0] data_out
);

    localparam int ADDR_W = bitSize + 1;
    localparam int ROW    = identifier / N;
    localparam int COL    = identifier % N;
    localparam bit BORDER = (ROW == 0) || (ROW == N - 1) ||
                            (COL == 0) || (COL == N - 1);

    // Border cells never form neighbour addresses; an interior stand-in
    // centre keeps every computed address inside the image, and only the
    // centre register is allowed to capture.
    localparam int C_SAFE = BORDER ? (N + 1) : identifier;

    // Address of neighbour register k (0 = P1 centre, 1..8 = P2..P9).
    function automatic logic [ADDR_W-1:0] nb_addr(input int k);
        int v;
        case (k)
            0:       v = identifier;
            1:       v = C_SAFE - N;
            2:       v = C_SAFE - N + 1;
            3:       v = C_SAFE + 1;
            4:       v = C_SAFE + N + 1;
            5:       v = C_SAFE + N;
            6:       v = C_SAFE + N - 1;
            7:       v = C_SAFE - 1;
            default: v = C_SAFE - N - 1;
        endcase
        return ADDR_W'(v);
    endfunction

    logic [pixelWidth-1:0] p_reg [9];
    logic [8:0]            hit;
    logic [8:0]            b;
    logic [3:0]            b_cnt;
    logic [3:0]            a_cnt;
    logic                  prod_a;
    logic                  prod_b;
    logic                  deletable;

    // Full-width address match against each neighbour; no modular wrap.
    always_comb begin
        hit = '0;
        for (int k = 0; k < 9; k++) begin
            hit[k] = (address == nb_addr(k)) && ((k == 0) || !BORDER);
        end
    end

    // Capture the neighbourhood; last write to an address wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                p_reg[k] <= '0;
            end
        end else if (we) begin
            for (int k = 0; k < 9; k++) begin
                if (hit[k]) begin
                    p_reg[k] <= data_in;
                end
            end
        end
    end

    // Binarize and evaluate the Zhang-Suen deletion test.
    always_comb begin
        b     = '0;
        b_cnt = '0;
        a_cnt = '0;
        for (int k = 0; k < 9; k++) begin
            b[k] = (p_reg[k] != '0);
        end
        for (int k = 1; k < 9; k++) begin
            b_cnt = b_cnt + 4'(b[k]);
            // Cyclic successor: after P9 (index 8) comes P2 (index 1).
            if (!b[k] && b[(k == 8) ? 1 : k + 1]) begin
                a_cnt = a_cnt + 4'd1;
            end
        end
`ifdef KERNEL_RAM_SUBITER2_EN
        prod_a = b[1] & b[3] & b[7];
        prod_b = b[1] & b[5] & b[7];
`else
        prod_a = b[1] & b[3] & b[5];
        prod_b = b[3] & b[5] & b[7];
`endif
        deletable = b[0] &&
                    (b_cnt >= 4'd2) && (b_cnt <= 4'd6) &&
                    (a_cnt == 4'd1) &&
                    !prod_a && !prod_b;
    end

    // Register the surviving centre pixel; border cells output padding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (BORDER || deletable) begin
            data_out <= '0;
        end else begin
            data_out <= p_reg[0];
        end
    end

endmodule

// File: tb/tb_kernel_ram.sv
// tb_kernel_ram: directed self-checking bench for kernel_ram.
// Two cells share one write stream: an interior cell (identifier 9, row 1
// col 1) and a border cell (identifier 0). Expected values are hand-derived
// from the Zhang-Suen rules.
module tb_kernel_ram;

    localparam int N  = 8;
    localparam int BS = 6;
    localparam int PW = 8;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [BS:0]   address;
    logic [PW-1:0] data_in;
    logic [PW-1:0] dout9;
    logic [PW-1:0] dout0;

    int checks;
    int errors;
    logic [PW-1:0] exp_q[$];

    kernel_ram #(.N(N), .bitSize(BS), .pixelWidth(PW), .identifier(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .we(we), .address(address),
        .data_in(data_in), .data_out(dout9)
    );

    kernel_ram #(.N(N), .bitSize(BS), .pixelWidth(PW), .identifier(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .address(address),
        .data_in(data_in), .data_out(dout0)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [PW-1:0] d);
        address = (BS+1)'(a);
        data_in = d;
        we      = 1'b1;
        tick(1);
        we      = 1'b0;
    endtask

    task automatic do_reset();
        we    = 1'b0;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    // Scoreboard: expected value queued, then popped against the observation.
    task automatic check(input string tag, input logic [PW-1:0] obs,
                         input logic [PW-1:0] exp);
        logic [PW-1:0] e;
        exp_q.push_back(exp);
        e = exp_q.pop_front();
        checks++;
        assert (obs === e)
        else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, e);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b1;
        we      = 1'b0;
        address = '0;
        data_in = '0;
        tick(1);

        // Reset wins over a simultaneous write to the centre.
        rst_n   = 1'b0;
        we      = 1'b1;
        address = 7'd9;
        data_in = 8'hFF;
        tick(1);
        check("reset_dout9", dout9, 8'h00);
        check("reset_dout0", dout0, 8'h00);
        rst_n = 1'b1;
        we    = 1'b0;
        tick(2);
        check("reset_release", dout9, 8'h00);

        // Isolated pixel: B=0, kept.
        wr(9, 8'hFF);
        tick(2);
        check("isolated", dout9, 8'hFF);

        // Non-neighbour and out-of-image addresses are ignored
        // (65/66/74 would alias to 1/2/10 and 73 to 9 under wrap).
        wr(3, 8'hFF); wr(11, 8'hFF); wr(19, 8'hFF); wr(27, 8'hFF);
        wr(65, 8'hFF); wr(66, 8'hFF); wr(74, 8'hFF); wr(73, 8'h00);
        tick(2);
        check("ignored_addrs", dout9, 8'hFF);

        // Repeated writes, held for 2 cycles; last value wins.
        wr(9, 8'h5A); wr(9, 8'h5A); wr(9, 8'h3C); wr(9, 8'h3C);
        tick(2);
        check("last_wins", dout9, 8'h3C);

        // Deletable corner: B=3, A=1, products 0 in both sub-iterations.
        do_reset();
        wr(1, 8'hFF); wr(2, 8'hFF); wr(9, 8'hFF); wr(10, 8'hFF);
        tick(2);
        check("corner", dout9, 8'h00);

        // Solid block: B=8, kept; border cell stays 0.
        do_reset();
        for (int a = 0; a < 3; a++) begin
            wr(a, 8'hFF); wr(a + 8, 8'hFF); wr(a + 16, 8'hFF);
        end
        tick(2);
        check("solid", dout9, 8'hFF);
        check("solid_border", dout0, 8'h00);

        // Mid-stream reset discards captured neighbours.
        do_reset();
        tick(2);
        check("midstream_reset", dout9, 8'h00);

        // Solid block driven with we=0 captures nothing.
        for (int a = 0; a < 3; a++) begin
            for (int r = 0; r < 3; r++) begin
                address = 7'(a + 8 * r);
                data_in = 8'hFF;
                tick(1);
            end
        end
        tick(2);
        check("solid_we0", dout9, 8'h00);

        // N and S only: B=2, A=2 -> kept; raw centre value returned.
        do_reset();
        wr(1, 8'hFF); wr(9, 8'h81); wr(17, 8'hFF);
        tick(2);
        check("a_eq_2", dout9, 8'h81);

        // B=1 (N only): below the lower bound -> kept.
        do_reset();
        wr(1, 8'h07); wr(9, 8'h24);
        tick(2);
        check("b_eq_1", dout9, 8'h24);

        // B=2 (N, NE): A=1, products 0 -> deleted.
        wr(2, 8'h01);
        tick(2);
        check("b_eq_2", dout9, 8'h00);

        // B=7 (all but NW): above the upper bound -> kept.
        do_reset();
        wr(1, 8'hFF); wr(2, 8'hFF); wr(8, 8'hFF); wr(9, 8'h42);
        wr(10, 8'hFF); wr(16, 8'hFF); wr(17, 8'hFF); wr(18, 8'hFF);
        tick(2);
        check("b_eq_7", dout9, 8'h42);

        // B=6 (S and SW clear): A=1, b2*b4*b6=0, b4*b6*b8=0 but b2*b4*b8=1.
        do_reset();
        wr(0, 8'hFF); wr(1, 8'hFF); wr(2, 8'hFF); wr(8, 8'hFF);
        wr(9, 8'h99); wr(10, 8'hFF); wr(18, 8'hFF);
        tick(2);
`ifdef KERNEL_RAM_SUBITER2_EN
        check("b_eq_6", dout9, 8'h99);
`else
        check("b_eq_6", dout9, 8'h00);
`endif

        // N, NE, E, SE, S: B=5, A=1, b2*b4*b6=1, b2*b4*b8=0, b2*b6*b8=0.
        do_reset();
        wr(1, 8'hFF); wr(2, 8'hFF); wr(9, 8'h66); wr(10, 8'hFF);
        wr(17, 8'hFF); wr(18, 8'hFF);
        tick(2);
`ifdef KERNEL_RAM_SUBITER2_EN
        check("prod_b246", dout9, 8'h00);
`else
        check("prod_b246", dout9, 8'h66);
`endif

        // W, NW, N, NE, E: B=5, A=1, b2*b4*b8=1, b2*b4*b6=0, b4*b6*b8=0.
        do_reset();
        wr(0, 8'hFF); wr(1, 8'hFF); wr(2, 8'hFF); wr(8, 8'hFF);
        wr(9, 8'h11); wr(10, 8'hFF);
        tick(2);
`ifdef KERNEL_RAM_SUBITER2_EN
        check("prod_b248", dout9, 8'h11);
`else
        check("prod_b248", dout9, 8'h00);
`endif

        // Full frame back-to-back: border cell 0, interior solid -> kept.
        do_reset();
        for (int a = 0; a < N * N; a++) begin
            address = 7'(a);
            data_in = 8'hFF;
            we      = 1'b1;
            tick(1);
        end
        we = 1'b0;
        tick(2);
        check("frame_border", dout0, 8'h00);
        check("frame_interior", dout9, 8'hFF);

        // No auto-clear: values hold with we=0.
        tick(5);
        check("hold", dout9, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
